// File: rtl/sseg_pkg.sv
// Shared glyph codes, converter state encoding and slot helpers for the
// multiplexed seven-segment scan controller.
package sseg_pkg;

    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_DEG   = 7'b0011100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_COMMIT
    } conv_state_t;

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] pos;
    } slot_pos_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Anode slot -> (channel, position within channel)
    function automatic slot_pos_t slot_decode(input int unsigned slot, input int unsigned per);
        slot_pos_t r;
        r.ch  = 8'(slot / per);
        r.pos = 8'(slot % per);
        return r;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Channel values / controls in, multiplexed segment and anode drive out.
interface sseg_scan_ctrl_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned NUM_DIG = 2,
    parameter int unsigned VAL_W   = 8
);
    localparam int unsigned NUM_AN = NUM_CH * (NUM_DIG + 2);

    logic [NUM_CH*VAL_W-1:0] ch_val;
    logic [NUM_CH-1:0]       ch_blink;
    logic                    unit_c;
    logic [6:0]              sseg_out;
    logic [NUM_AN-1:0]       an_out;
    logic                    frame_tick;
    logic [NUM_CH-1:0]       ovf;

    modport master (
        output ch_val, ch_blink, unit_c,
        input  sseg_out, an_out, frame_tick, ovf
    );

    modport slave (
        input  ch_val, ch_blink, unit_c,
        output sseg_out, an_out, frame_tick, ovf
    );
endinterface

// File: rtl/sseg_scan_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter; one bit per clock, MSB first.
module bin2bcd_seq #(
    parameter int unsigned VAL_W   = 8,
    parameter int unsigned NUM_DIG = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [VAL_W-1:0]       i_val,
    output logic                   o_busy,
    output logic                   o_done_c,
    output logic [4*NUM_DIG-1:0]   o_bcd
);
    localparam int unsigned BCD_W = 4 * NUM_DIG;
    localparam int unsigned CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [BCD_W-1:0] w_adj;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // Digits above NUM_DIG are dropped; lower digits are unaffected by that.
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                             : r_bcd[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_val;
            r_bcd  <= '0;
            r_cnt  <= CNT_W'(VAL_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[VAL_W-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
        end
    end

    assign o_busy   = r_busy;
    assign o_done_c = r_busy && (r_cnt == CNT_W'(1));
    assign o_bcd    = r_bcd;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-frame value capture, time-shared
// BCD conversion, leading-zero blanking, overflow dashes and per-channel blink.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned NUM_DIG      = 2,
    parameter int unsigned VAL_W        = 8,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned BLANK_LZ     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sseg_scan_ctrl_if.slave  bus
);
    localparam int unsigned PER     = NUM_DIG + 2;
    localparam int unsigned NUM_AN  = NUM_CH * PER;
    localparam int unsigned BCD_W   = 4 * NUM_DIG;
    localparam int unsigned DIV_W   = $clog2(REFRESH_DIV);
    localparam int unsigned SLOT_W  = $clog2(NUM_AN);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DIG_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int unsigned FCNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned OVF_LIM = pow10(NUM_DIG);

    logic [DIV_W-1:0]  r_div;
    logic [SLOT_W-1:0] r_slot;
    logic              r_tick;
    logic              w_div_tc;
    logic              w_frame_start;

    logic [VAL_W-1:0]  w_ch_val [NUM_CH];
    logic [VAL_W-1:0]  r_snap   [NUM_CH];
    logic [NUM_CH-1:0] w_snap_ovf;

    conv_state_t       r_state, w_state_nxt;
    logic              w_start, w_store, w_commit;
    logic [CH_W-1:0]   r_ch;
    logic              w_busy, w_done_c;
    logic [BCD_W-1:0]  w_bcd;

    logic [BCD_W-1:0]  r_shadow_bcd [NUM_CH];
    logic [NUM_CH-1:0] r_shadow_ovf;
    logic [BCD_W-1:0]  r_disp_bcd   [NUM_CH];
    logic [NUM_CH-1:0] r_ovf;
    logic              r_disp_valid;

    logic [FCNT_W-1:0] r_fcnt;
    logic              r_blink_phase;

    slot_pos_t         w_pos;
    logic [CH_W-1:0]   w_dch;
    logic [DIG_W-1:0]  w_dk;
    logic [BCD_W-1:0]  w_cur_bcd;
    logic [3:0]        w_digs [NUM_DIG];
    logic [NUM_DIG-1:0] w_hi_zero;
    logic [6:0]        w_glyph;
    logic [NUM_AN-1:0] w_an;
    logic [NUM_AN-1:0] r_an;
    logic [6:0]        r_sseg;

    assign w_div_tc      = (r_div == DIV_W'(REFRESH_DIV - 1));
    assign w_frame_start = w_div_tc && (r_slot == SLOT_W'(NUM_AN - 1));

    // Refresh divider and anode slot index; wrap to slot 0 marks a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_slot <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_frame_start;
            if (w_div_tc) begin
                r_div  <= '0;
                r_slot <= (r_slot == SLOT_W'(NUM_AN - 1)) ? '0 : r_slot + SLOT_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_ch_val[c]   = bus.ch_val[c*VAL_W +: VAL_W];
        assign w_snap_ovf[c] = (32'(r_snap[c]) >= OVF_LIM);
    end

    // Capture only when idle so a running conversion always sees a stable frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_snap <= '{default: '0};
        else if (w_frame_start && (r_state == ST_IDLE)) r_snap <= w_ch_val;
    end

    bin2bcd_seq #(
        .VAL_W   (VAL_W),
        .NUM_DIG (NUM_DIG)
    ) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_val    (r_snap[r_ch]),
        .o_busy   (w_busy),
        .o_done_c (w_done_c),
        .o_bcd    (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_store     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_frame_start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_start     = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT:  if (w_done_c || !w_busy) w_state_nxt = ST_STORE;
            ST_STORE: begin
                w_store     = 1'b1;
                w_state_nxt = (r_ch == CH_W'(NUM_CH - 1)) ? ST_COMMIT : ST_LOAD;
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow results per channel, then publish all channels together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch         <= '0;
            r_shadow_bcd <= '{default: '0};
            r_shadow_ovf <= '0;
            r_disp_bcd   <= '{default: '0};
            r_ovf        <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            if (w_store) begin
                r_shadow_bcd[r_ch] <= w_bcd;
                r_shadow_ovf[r_ch] <= w_snap_ovf[r_ch];
                r_ch <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
            end
            if (w_commit) begin
                r_disp_bcd   <= r_shadow_bcd;
                r_ovf        <= r_shadow_ovf;
                r_disp_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt        <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                r_fcnt        <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end

    assign w_pos     = slot_decode(32'(r_slot), PER);
    assign w_dch     = CH_W'(w_pos.ch);
    assign w_dk      = DIG_W'(w_pos.pos - 8'd2);
    assign w_cur_bcd = r_disp_bcd[w_dch];

    for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
        assign w_digs[k]    = w_cur_bcd[4*k +: 4];
        assign w_hi_zero[k] = (w_cur_bcd[BCD_W-1:4*k] == '0);
    end

    always_comb begin
        w_glyph = SEG_BLANK;
        if (w_pos.pos == 8'd0)                           w_glyph = bus.unit_c ? SEG_C : SEG_F;
        else if (w_pos.pos == 8'd1)                      w_glyph = SEG_DEG;
        else if (r_ovf[w_dch])                           w_glyph = SEG_DASH;
        else if ((BLANK_LZ != 0) && (w_dk != '0) && w_hi_zero[w_dk]) w_glyph = SEG_BLANK;
        else                                             w_glyph = digit_glyph(w_digs[w_dk]);
    end

    // Only the current slot's anode is ever low, so blanking it hides the channel
    always_comb begin
        w_an = ~(NUM_AN'(1) << r_slot);
        if (!r_disp_valid || (!r_blink_phase && bus.ch_blink[w_dch])) w_an = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an   <= '1;
            r_sseg <= SEG_BLANK;
        end else begin
            r_an   <= w_an;
            r_sseg <= w_glyph;
        end
    end

    assign bus.an_out     = r_an;
    assign bus.sseg_out   = r_sseg;
    assign bus.frame_tick = r_tick;
    assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl against a cycle-count based display model.
module tb_sseg_scan_ctrl;
    localparam int NCH   = 2;
    localparam int ND    = 2;
    localparam int VW    = 8;
    localparam int RDIV  = 4;
    localparam int BF    = 2;
    localparam int BLZ   = 1;
    localparam int PER   = ND + 2;
    localparam int S     = NCH * PER;
    localparam int FRAME = S * RDIV;
    localparam int LAT   = NCH * (VW + 2) + 1;
    localparam int LIM   = 10 ** ND;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sseg_scan_ctrl_if #(.NUM_CH(NCH), .NUM_DIG(ND), .VAL_W(VW)) u_if ();

    sseg_scan_ctrl #(
        .NUM_CH(NCH), .NUM_DIG(ND), .VAL_W(VW),
        .REFRESH_DIV(RDIV), .BLINK_FRAMES(BF), .BLANK_LZ(BLZ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    logic [6:0] tb_dig [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    int n_assert = 0;
    int n_fail   = 0;

    // Model: edges since reset release, values captured per frame, commit timing
    int t;
    int m_pend [NCH];
    int m_ovf_val [NCH];
    int m_disp_val [NCH];
    int m_pend_edge;
    bit m_valid, m_ovf_ok;

    task automatic model_reset();
        t = 0;
        m_valid = 0;
        m_ovf_ok = 0;
        m_pend_edge = -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input int c, input int p);
        int v, k;
        if (p == 0) return u_if.unit_c ? 7'b0110001 : 7'b0111000;
        if (p == 1) return 7'b0011100;
        v = m_disp_val[c];
        k = p - 2;
        if (v >= LIM) return 7'b1111110;
        if (BLZ != 0 && k > 0 && v < 10 ** k) return 7'b1111111;
        return tb_dig[(v / (10 ** k)) % 10];
    endfunction

    task automatic step();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_tick;
        logic [1:0] e_ovf;
        bit         chk_seg;
        int         s, c, p, phase;
        @(posedge clk);
        if (rst_n == 1'b0) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_tick = 1'b0; e_ovf = 2'b00; chk_seg = 1;
        end else begin
            t++;
            if (t % FRAME == 0) begin
                for (int i = 0; i < NCH; i++) m_pend[i] = int'(u_if.ch_val[i*VW +: VW]);
                m_pend_edge = t + LAT;
            end
            if (t == m_pend_edge) begin
                m_ovf_val = m_pend;
                m_ovf_ok  = 1;
            end
            if (t == m_pend_edge + 1) begin
                m_disp_val = m_pend;
                m_valid    = 1;
            end
            e_tick = (t % FRAME == 0);
            for (int i = 0; i < NCH; i++) e_ovf[i] = m_ovf_ok && (m_ovf_val[i] >= LIM);
            s = ((t - 1) / RDIV) % S;
            c = s / PER;
            p = s % PER;
            phase = (((t - 1) / FRAME) / BF) % 2;
            e_an = (!m_valid || (phase == 0 && u_if.ch_blink[c])) ? 8'hFF : ~(8'(1) << s);
            e_seg = exp_glyph(c, p);
            chk_seg = m_valid;
        end
        @(negedge clk);
        chk("an_out", 32'(u_if.an_out), 32'(e_an));
        if (chk_seg) chk("sseg_out", 32'(u_if.sseg_out), 32'(e_seg));
        chk("frame_tick", 32'(u_if.frame_tick), 32'(e_tick));
        chk("ovf", 32'(u_if.ovf), 32'(e_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_async_reset();
        chk("rst_an", 32'(u_if.an_out), 32'h0000_00FF);
        chk("rst_sseg", 32'(u_if.sseg_out), 32'h0000_007F);
        chk("rst_tick", 32'(u_if.frame_tick), 32'h0);
        chk("rst_ovf", 32'(u_if.ovf), 32'h0);
    endtask

    int dir0 [4] = '{5, 0, 9, 10};
    int dir1 [4] = '{150, 99, 100, 255};

    initial begin
        u_if.ch_val   = {8'd68, 8'd72};
        u_if.ch_blink = 2'b00;
        u_if.unit_c   = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk_async_reset();
        run(10);
        rst_n = 1'b1;

        // Pre-commit blanking, then F DEG 2 7 F DEG 8 6
        run(FRAME * 3 + 5);

        // Mid-frame change must wait for the next captured frame
        u_if.ch_val[7:0] = 8'd73;
        run(FRAME * 2 + 10);

        // Leading-zero, zero, overflow and boundary values
        for (int i = 0; i < 4; i++) begin
            u_if.ch_val = {8'(dir1[i]), 8'(dir0[i])};
            u_if.unit_c = 1'(i % 2);
            run(FRAME * 2 + 7 * i);
        end

        for (int i = 0; i < 6; i++) begin
            u_if.ch_val   = 16'($urandom);
            u_if.ch_blink = 2'($urandom_range(0, 3));
            u_if.unit_c   = 1'($urandom_range(0, 1));
            run(int'($urandom_range(FRAME, 3 * FRAME)));
        end

        // Blink only channel 1
        u_if.ch_val   = {8'd68, 8'd72};
        u_if.ch_blink = 2'b10;
        u_if.unit_c   = 1'b0;
        run(FRAME * 5);

        // Reset while the converter is shifting
        for (int i = 0; i < FRAME && (t % FRAME) != 5; i++) step();
        u_if.ch_val = {8'd42, 8'd7};
        rst_n = 1'b0;
        model_reset();
        #1 chk_async_reset();
        run(3);
        rst_n = 1'b1;
        run(FRAME * 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
